// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the ID/EX hazard inputs and the stall/flush
// controls exchanged between the pipeline datapath (master) and the
// hazard controller (slave).
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             id_mdu_start;
   logic             id_mdu_div;
   logic             id_mdu_read;
   logic [1:0]       ex_memread;
   logic [4:0]       ex_rt;
   logic             branch_taken;

   logic             pc_stall;
   logic             if_id_stall;
   logic             ex_bubble;
   logic             id_flush;
   logic             if_flush;
   logic             mdu_busy;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_mdu_start, id_mdu_div, id_mdu_read,
             ex_memread, ex_rt, branch_taken,
      input  pc_stall, if_id_stall, ex_bubble, id_flush, if_flush,
             mdu_busy, stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_mdu_start, id_mdu_div, id_mdu_read,
             ex_memread, ex_rt, branch_taken,
      output pc_stall, if_id_stall, ex_bubble, id_flush, if_flush,
             mdu_busy, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. Detects load-use hazards and,
// when HAZARD_MDU_EN is defined, tracks an in-flight multiply/divide and
// stalls any mult/div or HI/LO read issued while it is busy. Taken
// branches flush IF/ID and always win over stalls. Also keeps a
// saturating count of stalled cycles.
// Build option: define HAZARD_MDU_EN to include the MDU occupancy tracker;
// without it the MDU inputs are ignored and mdu_busy is tied low.
module hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 16
) (
   input logic         clk,
   input logic         reset,
   hazard_ctrl_if.slave hz
);

   // Counter preload values: busy lasts LAT-1 cycles after the issue cycle.
   localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

`ifdef HAZARD_MDU_EN
   typedef enum logic [1:0] {IDLE = 2'd0, LDSTALL = 2'd1, MDUWAIT = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, LDSTALL = 2'd1} state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic             ldu;
   logic             mduh;
   logic             stall;
   logic             flush;

`ifdef HAZARD_MDU_EN
   logic [5:0]       mdu_cnt_q, mdu_cnt_d;
`else
   logic             unused_mdu;
   assign unused_mdu = ^{hz.id_mdu_start, hz.id_mdu_div, hz.id_mdu_read,
                         MUL_LOAD, DIV_LOAD};
`endif

   // Hazard detection; reset and taken branches suppress every stall.
   always_comb begin
      ldu = (hz.ex_memread != 2'b00) && (hz.ex_rt != 5'd0) &&
            ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
             (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));
`ifdef HAZARD_MDU_EN
      mduh = (state_q == MDUWAIT) && (hz.id_mdu_start || hz.id_mdu_read);
`else
      mduh = 1'b0;
`endif
      stall = (ldu || mduh) && !hz.branch_taken && !reset;
      flush = hz.branch_taken && !reset;
   end

   // Next-state logic; an MDU operation in flight is never aborted by a branch.
   always_comb begin
      state_d = state_q;
`ifdef HAZARD_MDU_EN
      mdu_cnt_d = mdu_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (ldu && !hz.branch_taken) begin
               state_d = LDSTALL;
            end
`ifdef HAZARD_MDU_EN
            else if (hz.id_mdu_start && !stall && !hz.branch_taken) begin
               state_d   = MDUWAIT;
               mdu_cnt_d = hz.id_mdu_div ? DIV_LOAD : MUL_LOAD;
            end
`endif
         end
         LDSTALL: begin
            state_d = (ldu && !hz.branch_taken) ? LDSTALL : IDLE;
         end
`ifdef HAZARD_MDU_EN
         MDUWAIT: begin
            mdu_cnt_d = mdu_cnt_q - 6'd1;
            if (mdu_cnt_q == 6'd1) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Stall counter advances on stalled cycles and sticks at all-ones.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   // State register with synchronous reset, also effective mid-operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         stall_cycles_q <= '0;
`ifdef HAZARD_MDU_EN
         mdu_cnt_q      <= 6'd0;
`endif
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
`ifdef HAZARD_MDU_EN
         mdu_cnt_q      <= mdu_cnt_d;
`endif
      end
   end

   // Output decode: stall/flush are combinational, busy comes from state.
   always_comb begin
      hz.pc_stall     = stall;
      hz.if_id_stall  = stall;
      hz.ex_bubble    = stall;
      hz.id_flush     = flush;
      hz.if_flush     = flush;
`ifdef HAZARD_MDU_EN
      hz.mdu_busy     = (state_q == MDUWAIT);
`else
      hz.mdu_busy     = 1'b0;
`endif
      hz.stall_cycles = stall_cycles_q;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors, directed multi-cycle sequences and a
// randomized run compared against a cycle-level reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl;
   localparam int MUL = 4;
   localparam int DIV = 32;
   localparam int CW  = 16;
`ifdef HAZARD_MDU_EN
   localparam bit MDU_EN = 1'b1;
`else
   localparam bit MDU_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(CW)) bus();
   hazard_ctrl_if #(.CNT_W(4))  sbus();

   hazard_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .hz(bus)
   );

   // Narrow-counter instance used to reach saturation in few cycles.
   hazard_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .hz(sbus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: busy cycles remaining, load-stall flag, stall count.
   int m_rem = 0;
   bit m_ld  = 1'b0;
   int m_cnt = 0;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic [1:0] mr;
      logic [4:0] ert;
      logic       bt;
      logic       stall;
      logic       flush;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit f_ldu();
      return (bus.ex_memread != 2'b00) && (bus.ex_rt != 5'd0) &&
             ((bus.id_uses_rs && bus.id_rs == bus.ex_rt) ||
              (bus.id_uses_rt && bus.id_rt == bus.ex_rt));
   endfunction

   task automatic idle_inputs();
      bus.id_rs = 5'd0; bus.id_rt = 5'd0;
      bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
      bus.id_mdu_start = 1'b0; bus.id_mdu_div = 1'b0; bus.id_mdu_read = 1'b0;
      bus.ex_memread = 2'b00; bus.ex_rt = 5'd0; bus.branch_taken = 1'b0;
   endtask

   // One clock cycle: check outputs against the model, then advance both.
   task automatic step();
      bit ldu, mduh, stall, bt, start, div;
      #1;
      ldu   = f_ldu();
      bt    = bus.branch_taken;
      start = bus.id_mdu_start;
      div   = bus.id_mdu_div;
      mduh  = MDU_EN && (m_rem > 0) && (bus.id_mdu_start || bus.id_mdu_read);
      stall = (ldu || mduh) && !bt && !reset;
      chk("pc_stall",     32'(bus.pc_stall),     32'(stall));
      chk("if_id_stall",  32'(bus.if_id_stall),  32'(stall));
      chk("ex_bubble",    32'(bus.ex_bubble),    32'(stall));
      chk("id_flush",     32'(bus.id_flush),     32'(bt && !reset));
      chk("if_flush",     32'(bus.if_flush),     32'(bt && !reset));
      chk("mdu_busy",     32'(bus.mdu_busy),     32'(m_rem > 0));
      chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_cnt));
      @(posedge clk);
      if (reset) begin
         m_rem = 0; m_ld = 1'b0; m_cnt = 0;
      end else begin
         if (stall && m_cnt < (1 << CW) - 1) m_cnt++;
         if (m_rem > 0) begin
            m_rem--;
            m_ld = 1'b0;
         end else begin
            if (MDU_EN && !m_ld && start && !stall && !bt)
               m_rem = div ? DIV - 1 : MUL - 1;
            m_ld = ldu && !bt;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      int busy_n;
      idle_inputs();
      sbus.id_rs = 5'd3; sbus.id_rt = 5'd0;
      sbus.id_uses_rs = 1'b1; sbus.id_uses_rt = 1'b0;
      sbus.id_mdu_start = 1'b0; sbus.id_mdu_div = 1'b0; sbus.id_mdu_read = 1'b0;
      sbus.ex_memread = 2'b01; sbus.ex_rt = 5'd3; sbus.branch_taken = 1'b0;

      tbl[0] = '{5'd5,  5'd0, 1'b1, 1'b0, 2'b01, 5'd5,  1'b0, 1'b1, 1'b0};
      tbl[1] = '{5'd5,  5'd0, 1'b1, 1'b0, 2'b01, 5'd0,  1'b0, 1'b0, 1'b0};
      tbl[2] = '{5'd5,  5'd0, 1'b1, 1'b0, 2'b01, 5'd5,  1'b1, 1'b0, 1'b1};
      tbl[3] = '{5'd7,  5'd9, 1'b1, 1'b1, 2'b10, 5'd9,  1'b0, 1'b1, 1'b0};
      tbl[4] = '{5'd7,  5'd9, 1'b1, 1'b0, 2'b10, 5'd9,  1'b0, 1'b0, 1'b0};
      tbl[5] = '{5'd7,  5'd9, 1'b1, 1'b1, 2'b00, 5'd7,  1'b0, 1'b0, 1'b0};
      tbl[6] = '{5'd31, 5'd2, 1'b1, 1'b0, 2'b11, 5'd31, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{5'd4,  5'd6, 1'b1, 1'b1, 2'b00, 5'd0,  1'b1, 1'b0, 1'b1};
      tbl[8] = '{5'd8,  5'd3, 1'b0, 1'b1, 2'b01, 5'd8,  1'b0, 1'b0, 1'b0};
      tbl[9] = '{5'd12, 5'd12,1'b1, 1'b1, 2'b01, 5'd12, 1'b0, 1'b1, 1'b0};

      // Initial reset, then reset-state values and outputs held low under reset.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",   32'(bus.mdu_busy),     32'd0);
      chk("rst_count",  32'(bus.stall_cycles), 32'd0);
      bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1; bus.ex_memread = 2'b01;
      bus.ex_rt = 5'd5; bus.branch_taken = 1'b1; bus.id_mdu_start = 1'b1;
      #1;
      chk("rst_pc_stall", 32'(bus.pc_stall), 32'd0);
      chk("rst_id_flush", 32'(bus.id_flush), 32'd0);
      step();
      chk("rst_busy_after", 32'(bus.mdu_busy), 32'd0);
      reset = 1'b0;
      idle_inputs();

      // Load-use: one stall cycle counted.
      do_reset();
      bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1; bus.ex_memread = 2'b01; bus.ex_rt = 5'd5;
      #1;
      chk("ldu_stall", 32'(bus.pc_stall), 32'd1);
      step();
      idle_inputs();
      #1;
      chk("ldu_release", 32'(bus.pc_stall),     32'd0);
      chk("ldu_count",   32'(bus.stall_cycles), 32'd1);
      step();

      // Load to r0 never stalls.
      do_reset();
      bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1; bus.ex_memread = 2'b01; bus.ex_rt = 5'd0;
      step();
      idle_inputs();
      #1;
      chk("r0_count", 32'(bus.stall_cycles), 32'd0);
      step();

      // Table vectors.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         bus.id_rs = tbl[i].rs; bus.id_rt = tbl[i].rt;
         bus.id_uses_rs = tbl[i].urs; bus.id_uses_rt = tbl[i].urt;
         bus.ex_memread = tbl[i].mr; bus.ex_rt = tbl[i].ert;
         bus.branch_taken = tbl[i].bt;
         #1;
         chk($sformatf("vec%0d_pc_stall", i),  32'(bus.pc_stall),    32'(tbl[i].stall));
         chk($sformatf("vec%0d_if_id", i),     32'(bus.if_id_stall), 32'(tbl[i].stall));
         chk($sformatf("vec%0d_bubble", i),    32'(bus.ex_bubble),   32'(tbl[i].stall));
         chk($sformatf("vec%0d_id_flush", i),  32'(bus.id_flush),    32'(tbl[i].flush));
         chk($sformatf("vec%0d_if_flush", i),  32'(bus.if_flush),    32'(tbl[i].flush));
         step();
      end

      // Divide issue, then HI/LO read held until the unit frees up.
      do_reset();
      bus.id_mdu_start = 1'b1; bus.id_mdu_div = 1'b1;
      #1;
      chk("div_pre_busy", 32'(bus.mdu_busy), 32'd0);
      step();
      bus.id_mdu_start = 1'b0; bus.id_mdu_read = 1'b1;
      busy_n = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (!bus.mdu_busy) break;
         busy_n++;
         chk("div_read_stall", 32'(bus.pc_stall), 32'd1);
         step();
      end
      chk("div_busy_len",  32'(busy_n),           MDU_EN ? 32'd31 : 32'd0);
      chk("mfhi_proceeds", 32'(bus.pc_stall),     32'd0);
      chk("div_count",     32'(bus.stall_cycles), MDU_EN ? 32'd31 : 32'd0);
      step();

      // Multiply issue, reset two cycles later clears busy and the counter.
      do_reset();
      bus.id_mdu_start = 1'b1; bus.id_mdu_div = 1'b0;
      step();
      bus.id_mdu_start = 1'b0; bus.id_mdu_read = 1'b1;
      step();
      step();
      chk("mul_busy",  32'(bus.mdu_busy),     32'(MDU_EN));
      chk("mul_count", 32'(bus.stall_cycles), MDU_EN ? 32'd2 : 32'd0);
      reset = 1'b1;
      #1;
      chk("mul_rst_stall", 32'(bus.pc_stall), 32'd0);
      step();
      reset = 1'b0;
      chk("mul_rst_busy",  32'(bus.mdu_busy),     32'd0);
      chk("mul_rst_count", 32'(bus.stall_cycles), 32'd0);
      idle_inputs();

      // Counter saturation on the narrow instance (stalls every cycle).
      do_reset();
      repeat (14) step();
      chk("sat_count14", 32'(sbus.stall_cycles), 32'd14);
      step();
      chk("sat_count15", 32'(sbus.stall_cycles), 32'd15);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("sat_hold",  32'(sbus.stall_cycles), 32'd15);
         chk("sat_stall", 32'(sbus.pc_stall),     32'd1);
      end

      // Randomized run against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         reset             = ($urandom_range(0, 63) == 0);
         bus.id_rs         = 5'($urandom_range(0, 3));
         bus.id_rt         = 5'($urandom_range(0, 3));
         bus.id_uses_rs    = 1'($urandom_range(0, 1));
         bus.id_uses_rt    = 1'($urandom_range(0, 1));
         bus.ex_memread    = 2'($urandom_range(0, 3));
         bus.ex_rt         = 5'($urandom_range(0, 3));
         bus.branch_taken  = ($urandom_range(0, 7) == 0);
         bus.id_mdu_start  = ($urandom_range(0, 9) == 0);
         bus.id_mdu_div    = 1'($urandom_range(0, 1));
         bus.id_mdu_read   = ($urandom_range(0, 3) == 0);
         step();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
